// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: PC register, single-outstanding imem request, decode handoff
module pc_fetch_unit #(
  parameter int                WORD     = 32,
  parameter logic [WORD-1:0]   RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [WORD-1:0] branch_target,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [WORD-1:0] imem_rdata,
  output logic            id_valid,
  output logic [WORD-1:0] id_instr,
  output logic [WORD-1:0] id_pc,
  input  logic            id_ready
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state, state_next;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] fetch_pc;
  logic            handshake;
  logic            advance;
  logic            load;

  assign imem_addr = pc;

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    load       = 1'b0;
    // Only request when the output register will be free to take the response.
    imem_req   = !rst && (state == S_ISSUE) && (!id_valid || id_ready);
    handshake  = imem_req && imem_gnt;
    case (state)
      S_ISSUE: begin
        if (branch_taken) begin
          state_next = handshake ? S_DROP : S_ISSUE;
        end else if (handshake) begin
          state_next = S_WAIT;
          advance    = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_next = S_ISSUE;
          load       = !branch_taken;
        end else if (branch_taken) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_next = S_ISSUE;
        end
      end
      default: state_next = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ISSUE;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      state <= state_next;

      if (branch_taken) begin
        pc <= branch_target;
      end else if (advance) begin
        pc <= pc + WORD'(PC_STEP);
      end

      if (advance) begin
        fetch_pc <= pc;
      end

      // A redirect flushes decode even if decode is accepting this cycle.
      if (branch_taken) begin
        id_valid <= 1'b0;
      end else if (load) begin
        id_valid <= 1'b1;
        id_instr <= imem_rdata;
        id_pc    <= fetch_pc;
      end else if (id_valid && id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.WORD(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_ready     (id_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", id_pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", id_instr, e.instr);
        check("sb_pc", id_pc, e.pc);
      end
    end
  end

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    step();
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // basic fetch
    rst = 1'b0; id_ready = 1'b1; imem_gnt = 1'b1; #1;
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'd0);
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'd654; push(32'd654, 32'd0); #1;
    check("t1_wait_req", 32'(imem_req), 32'd0);
    step();
    imem_rvalid = 1'b0;
    check("t1_valid", 32'(id_valid), 32'd1);
    check("t1_instr", id_instr, 32'd654);
    check("t1_idpc", id_pc, 32'd0);
    check("t1_next_addr", imem_addr, 32'd4);

    // decode backpressure
    imem_gnt = 1'b1; #1;
    check("t2_req", 32'(imem_req), 32'd1);
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'd15; push(32'd15, 32'd4); id_ready = 1'b0;
    step();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall_req", 32'(imem_req), 32'd0);
      check("t2_hold_valid", 32'(id_valid), 32'd1);
      check("t2_hold_instr", id_instr, 32'd15);
      check("t2_hold_pc", id_pc, 32'd4);
      step();
    end
    id_ready = 1'b1; #1;
    check("t2_req", 32'(imem_req), 32'd1);
    check("t2_addr", imem_addr, 32'd8);
    step();

    // redirect while waiting
    imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'd7110;
    step();
    branch_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'd43778; #1;
    check("t3_drop_req", 32'(imem_req), 32'd0);
    step();
    imem_rvalid = 1'b0; #1;
    check("t3_valid", 32'(id_valid), 32'd0);
    check("t3_req", 32'(imem_req), 32'd1);
    check("t3_addr", imem_addr, 32'd7110);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'd654; push(32'd654, 32'd7110);
    step();
    imem_rvalid = 1'b0;
    check("t3_valid2", 32'(id_valid), 32'd1);
    check("t3_idpc", id_pc, 32'd7110);
    step();

    // redirect in the same cycle as a grant
    branch_taken = 1'b1; branch_target = 32'd8;
    step();
    branch_target = 32'h100; imem_gnt = 1'b1; #1;
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'd8);
    step();
    branch_taken = 1'b0; imem_gnt = 1'b0; #1;
    check("t4_drop_req", 32'(imem_req), 32'd0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hdead;
    step();
    imem_rvalid = 1'b0; #1;
    check("t4_valid", 32'(id_valid), 32'd0);
    check("t4_req2", 32'(imem_req), 32'd1);
    check("t4_addr2", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234; push(32'h1234, 32'h100);
    step();
    imem_rvalid = 1'b0;
    check("t4_idpc", id_pc, 32'h100);

    // PC wraparound
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0; imem_gnt = 1'b1; #1;
    check("t5_addr", imem_addr, 32'hFFFF_FFFC);
    check("t5_req", 32'(imem_req), 32'd1);
    step();
    imem_gnt = 1'b0;
    check("t5_wrap", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'd77; push(32'd77, 32'hFFFF_FFFC);
    step();
    imem_rvalid = 1'b0; #1;
    check("t5_idpc", id_pc, 32'hFFFF_FFFC);
    check("t5_next_req", 32'(imem_req), 32'd1);
    check("t5_next_addr", imem_addr, 32'h0);

    // reset during an outstanding fetch
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; rst = 1'b1;
    step();
    check("t6_valid", 32'(id_valid), 32'd0);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'd99; #1;
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", imem_addr, 32'd0);
    step();
    imem_rvalid = 1'b0; #1;
    check("t6_late_valid", 32'(id_valid), 32'd0);
    check("t6_req2", 32'(imem_req), 32'd1);
    check("t6_addr2", imem_addr, 32'd0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'd5; push(32'd5, 32'd0);
    step();
    imem_rvalid = 1'b0;
    check("t6_instr", id_instr, 32'd5);
    step();
    step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
